// File: rtl/my_serial_addsub.sv
// my_serial_addsub: digit-serial adder/subtractor, DIGIT bits per cycle over WIDTH/DIGIT cycles
// Ports:
//   clk, rst             clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready    operand handshake for a, b and sub (sub=1 selects a-b)
//   res_valid/res_ready  result handshake; sum, cout (1 = no borrow on subtract), ovf (signed overflow)
module my_serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("my_serial_addsub: need WIDTH >= 2, 1 <= DIGIT <= WIDTH, WIDTH %% DIGIT == 0");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] a_r, b_r;
  logic carry, cc, c_msb;
  logic [DIGIT-1:0] s_d;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  // One DIGIT-wide ripple slice; c_msb ends as the carry into the slice's top bit,
  // which on the last digit is the carry into the operand MSB.
  always_comb begin
    cc = carry;
    c_msb = carry;
    s_d = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = cc;
      s_d[i] = a_r[i] ^ b_r[i] ^ cc;
      cc = (a_r[i] & b_r[i]) | (cc & (a_r[i] ^ b_r[i]));
    end
  end
  assign sum_cat = {s_d, sum};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      a_r <= '0;
      b_r <= '0;
      carry <= 1'b0;
      in_ready <= 1'b1;
      res_valid <= 1'b0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r <= a;
          b_r <= sub ? ~b : b;
          carry <= sub;
          count <= '0;
          in_ready <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          sum <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          a_r <= a_r >> DIGIT;
          b_r <= b_r >> DIGIT;
          carry <= cc;
          count <= count + CW'(1);
          if (count == CW'(N - 1)) begin
            cout <= cc;
            ovf <= cc ^ c_msb;
            res_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
